// File: rtl/fp12_pkg.sv
// rtl/fp12_pkg.sv - FP12 field layout, constants and accumulator FSM states
package fp12_pkg;

   localparam int SIGN_BIT = 11;
   localparam int EXP_MSB  = 10;
   localparam int EXP_LSB  = 7;
   localparam int MAN_MSB  = 6;
   localparam int MAN_LSB  = 0;

   localparam logic [11:0] FP12_POS_ZERO = 12'h000;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCEPT = 2'd1,
      ADD    = 2'd2,
      DONE   = 2'd3
   } acc_state_t;

   function automatic logic [11:0] fp12_negate(input logic [11:0] v);
      logic [11:0] r;
      r           = v;
      r[SIGN_BIT] = ~v[SIGN_BIT];
      return r;
   endfunction

endpackage

// File: rtl/fp12_accumulator.sv
// rtl/fp12_accumulator.sv - sequences a stream of FP12 terms through an external adder
module fp12_accumulator
   import fp12_pkg::*;
#(
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             sub_mode,
   input  logic             in_valid,
   input  logic [11:0]      in_data,
   output logic             in_ready,
   output logic [11:0]      add_x,
   output logic [11:0]      add_y,
   output logic             add_sub,
   input  logic [11:0]      add_result,
   output logic             out_valid,
   output logic [11:0]      out_data,
   input  logic             out_ready,
   output logic             busy
);

   acc_state_t       r_state;
   logic [11:0]      r_acc;
   logic [11:0]      r_opnd;
   logic [LEN_W-1:0] r_remaining;
   logic             r_first;
   logic             r_sub_q;
   logic             w_last;

   assign w_last    = (r_remaining == LEN_W'(1));

   assign in_ready  = (r_state == ACCEPT);
   assign out_valid = (r_state == DONE);
   assign busy      = (r_state != IDLE);
   assign add_x     = r_acc;
   assign add_y     = r_opnd;
   assign add_sub   = r_sub_q & (r_state == ADD);
   assign out_data  = r_acc;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_acc       <= FP12_POS_ZERO;
         r_opnd      <= FP12_POS_ZERO;
         r_remaining <= '0;
         r_first     <= 1'b0;
         r_sub_q     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_sub_q     <= sub_mode;
                  r_remaining <= len;
                  r_acc       <= FP12_POS_ZERO;
                  r_first     <= 1'b1;
                  r_state     <= (len == '0) ? DONE : ACCEPT;
               end
            end
            ACCEPT: begin
               if (in_valid) begin
                  // First term loads the sum directly so the adder never sees a zero operand.
                  if (r_first) begin
                     r_acc       <= r_sub_q ? fp12_negate(in_data) : in_data;
                     r_first     <= 1'b0;
                     r_remaining <= r_remaining - LEN_W'(1);
                     r_state     <= w_last ? DONE : ACCEPT;
                  end else begin
                     r_opnd  <= in_data;
                     r_state <= ADD;
                  end
               end
            end
            ADD: begin
               r_acc       <= add_result;
               r_remaining <= r_remaining - LEN_W'(1);
               r_state     <= w_last ? DONE : ACCEPT;
            end
            DONE: begin
               if (out_ready) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp12_accumulator.sv
// tb/tb_fp12_accumulator.sv - randomized self-checking bench for fp12_accumulator
module tb_fp12_accumulator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [3:0]  len;
   logic        sub_mode;
   logic        in_valid;
   logic [11:0] in_data;
   logic        in_ready;
   logic [11:0] add_x;
   logic [11:0] add_y;
   logic        add_sub;
   logic [11:0] add_result;
   logic        out_valid;
   logic [11:0] out_data;
   logic        out_ready;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;

   logic [1:0]  stub_mode;
   logic [11:0] seq_val;
   logic [11:0] terms [16];
   logic [11:0] seqs  [16];

   always #5 clk = ~clk;

   fp12_accumulator #(.LEN_W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .len        (len),
      .sub_mode   (sub_mode),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .add_x      (add_x),
      .add_y      (add_y),
      .add_sub    (add_sub),
      .add_result (add_result),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .busy       (busy)
   );

   // Stand-in adder: a deterministic scramble of its operands, not real FP arithmetic.
   function automatic logic [11:0] fake_add(input logic [11:0] x, input logic [11:0] y, input logic s);
      return x + (s ? ~y : y) + 12'h05A;
   endfunction

   always_comb begin
      add_result = 12'hFFF;
      case (stub_mode)
         2'd0:    add_result = 12'hFFF;
         2'd1:    add_result = seq_val;
         default: add_result = fake_add(add_x, add_y, add_sub);
      endcase
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic feed(input logic [11:0] d, input int gap, output bit ok);
      int k;
      ok = 1'b1;
      in_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = d;
      k = 0;
      while (!in_ready && k < 10) begin
         @(posedge clk); #1;
         k++;
      end
      if (!in_ready) begin
         check_eq("in_ready_timeout", 32'(in_ready), 32'd1);
         ok = 1'b0;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = 12'($urandom);
   endtask

   task automatic run_job(input int n, input logic sm, input int hold, input bit poke_start);
      logic [11:0] m;
      bit ok;
      start    = 1'b1;
      len      = n[3:0];
      sub_mode = sm;
      @(posedge clk); #1;
      start    = 1'b0;
      len      = 4'($urandom);
      sub_mode = 1'($urandom);
      check_eq("busy_after_start", 32'(busy), 32'd1);
      m = 12'h000;
      for (int i = 0; i < n; i++) begin
         feed(terms[i], int'($urandom_range(0, 2)), ok);
         if (!ok) return;
         if (i == 0) begin
            m = sm ? (terms[0] ^ 12'h800) : terms[0];
            if (n > 1) check_eq("add_sub_accept", 32'(add_sub), 32'd0);
         end else begin
            check_eq("add_x", 32'(add_x), 32'(m));
            check_eq("add_y", 32'(add_y), 32'(terms[i]));
            check_eq("add_sub", 32'(add_sub), 32'(sm));
            check_eq("in_ready_add", 32'(in_ready), 32'd0);
            seq_val = seqs[i-1];
            if (stub_mode == 2'd0)      m = 12'hFFF;
            else if (stub_mode == 2'd1) m = seqs[i-1];
            else                        m = fake_add(m, terms[i], sm);
            @(posedge clk); #1;
         end
      end
      check_eq("out_valid", 32'(out_valid), 32'd1);
      check_eq("out_data", 32'(out_data), 32'(m));
      check_eq("add_sub_done", 32'(add_sub), 32'd0);
      check_eq("in_ready_done", 32'(in_ready), 32'd0);
      for (int h = 0; h < hold; h++) begin
         if (poke_start && h == 1) start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         check_eq("hold_valid", 32'(out_valid), 32'd1);
         check_eq("hold_data", 32'(out_data), 32'(m));
         check_eq("hold_busy", 32'(busy), 32'd1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_eq("valid_after_pop", 32'(out_valid), 32'd0);
      check_eq("busy_after_pop", 32'(busy), 32'd0);
   endtask

   initial begin
      bit ok;
      int n;
      stub_mode = 2'd0;
      seq_val   = 12'h000;
      rst_n     = 1'b0;
      start     = 1'b1;
      len       = 4'd3;
      sub_mode  = 1'b1;
      in_valid  = 1'b1;
      in_data   = 12'h123;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_in_ready", 32'(in_ready), 32'd0);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_add_x", 32'(add_x), 32'h000);
      check_eq("rst_add_y", 32'(add_y), 32'h000);
      check_eq("rst_add_sub", 32'(add_sub), 32'd0);
      rst_n    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      @(posedge clk); #1;

      terms[0] = 12'h3C0; terms[1] = 12'h340; terms[2] = 12'h2C0;
      seqs[0]  = 12'h111; seqs[1]  = 12'h222;
      run_job(1, 1'b0, 0, 1'b0);
      run_job(1, 1'b1, 0, 1'b0);
      stub_mode = 2'd1;
      run_job(3, 1'b0, 0, 1'b0);
      run_job(3, 1'b1, 0, 1'b0);
      stub_mode = 2'd2;
      run_job(0, 1'b0, 5, 1'b1);

      // Abort mid-job: two terms in, then reset while back in ACCEPT.
      start = 1'b1; len = 4'd3; sub_mode = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      feed(12'h3C0, 0, ok);
      feed(12'h340, 0, ok);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check_eq("abort_busy", 32'(busy), 32'd0);
      check_eq("abort_acc", 32'(add_x), 32'h000);
      check_eq("abort_opnd", 32'(add_y), 32'h000);
      check_eq("abort_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      check_eq("abort_no_result", 32'(out_valid), 32'd0);
      terms[0] = 12'h2A5;
      run_job(1, 1'b1, 1, 1'b0);

      for (int j = 0; j < 25; j++) begin
         n = int'($urandom_range(0, 15));
         for (int t = 0; t < 16; t++) terms[t] = 12'($urandom);
         run_job(n, 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
